alu_share_ctrl: RTL
===================

Name: alu_share_ctrl

Overview:
- Sequencer and arbiter that shares one 8-bit alu_conv datapath between two requesters.
- Accepts operations over per-requester valid/ready handshakes and arbitrates round-robin.
- Drives the ALU's a0_mux/a1_mux/a_sel/b/ctrl inputs, holds operands stable for a programmable settle time, captures the ALU output, and returns it over a single tagged response handshake.
- Sits between the instruction-issue logic and the shared ALU instance.

Parameters:
- WIDTH, 8, operand/result width; must match the ALU.
- EXEC_CYCLES, 1, cycles the ALU inputs are held before the result is captured; legal range 1..15.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req0_valid  input  1  requester 0 has an operation.
- req0_ready  output  1  requester 0 operation accepted this cycle.
- req0_op  input  3  op code: 000 ADD, 001 SUB, 010 OR, 011 AND, 100 XOR, 101 NOT, 110 LSL, 111 LSR.
- req0_a  input  WIDTH  operand A.
- req0_b  input  WIDTH  operand B.
- req1_valid, req1_ready, req1_op, req1_a, req1_b  as requester 0.
- alu_a0  output  WIDTH  ALU a0_mux; carries requester 0's latched A.
- alu_a1  output  WIDTH  ALU a1_mux; carries requester 1's latched A.
- alu_a_sel  output  1  ALU a_sel; 0 selects a0_mux, 1 selects a1_mux; equals granted id.
- alu_b  output  WIDTH  ALU b; latched B of granted request.
- alu_ctrl  output  3  ALU ctrl; latched op of granted request.
- alu_out  input  WIDTH  combinational ALU result.
- rsp_valid  output  1  result available.
- rsp_ready  input  1  consumer accepts result.
- rsp_id  output  1  requester that owns the result.
- rsp_data  output  WIDTH  captured ALU result.
- rsp_zero  output  1  rsp_data == 0.
- busy  output  1  state != IDLE.

Behaviour:
- Only clk and rst_n are used for sequencing. rst_n low forces state IDLE asynchronously, plus:
  - all alu_* outputs, rsp_data, rsp_id and rsp_zero = 0;
  - rsp_valid = 0, busy = 0, exec counter = 0;
  - last_grant = 1, so requester 0 wins the first tie.
- States and transitions:
  - IDLE -> EXEC on acceptance.
  - EXEC -> RESP when the exec counter reaches EXEC_CYCLES-1.
  - RESP -> IDLE on rsp_valid & rsp_ready.
- IDLE:
  - reqK_ready is combinational: high only for the selected requester. Selection is the sole valid requester, or ~last_grant if both are valid. Both ready = 0 if neither is valid. The two readys are never high together.
  - On acceptance, register op/a/b. The A operand goes to alu_a0 or alu_a1 by id; the other alu_aX keeps its previous value.
  - Also on acceptance: set alu_a_sel = id, last_grant = id, counter = 0, and enter EXEC.
- EXEC:
  - alu_* outputs are stable; counter increments each cycle.
  - On the cycle the counter equals EXEC_CYCLES-1, capture alu_out into rsp_data, set rsp_zero, rsp_id = alu_a_sel, and rsp_valid = 1 (next cycle); enter RESP.
- RESP:
  - rsp_* are held stable while rsp_valid & ~rsp_ready; both req_ready = 0.
  - On handshake, rsp_valid drops the next cycle and state returns to IDLE. A new request may be accepted the cycle after that.
  - No accept occurs in the same cycle as the response handshake.
- Latency: accept at cycle N, rsp_valid high at N+EXEC_CYCLES+1. Back-to-back throughput is one op per EXEC_CYCLES+2 cycles when rsp_ready is tied high.
- ALU outputs persist after completion until the next accept.
- Requests are not dropped: a requester holding valid without ready keeps its payload. The controller samples the payload only on its own ready cycle.
- Fairness: with both requesters continuously valid, grants strictly alternate 0,1,0,1.
- Reset mid-operation (EXEC or RESP):
  - the in-flight op is discarded; rsp_valid goes low immediately;
  - after release, the first tie goes to requester 0.
- Width: the controller performs no arithmetic on data and passes the ALU result through unmodified. Op codes are not checked.

Test Plan:
- Single ADD, EXEC_CYCLES=1, rsp_ready=1: req0 op 000, a=08, b=10. Required: alu_a_sel=0, alu_a0=08; rsp_id=0, rsp_data=18, rsp_zero=0, rsp_valid exactly 2 cycles after accept.
- Simultaneous requests: req0 SUB a=80 b=03 and req1 SUB a=55 b=10, both valid from reset. Required: req0 is served first with rsp_data=7D, id 0; then req1 with rsp_data=45, id 1 and alu_a_sel=1.
- Fairness: both requesters always valid with XOR ops for 6 ops. Required: rsp_id sequence 0,1,0,1,0,1 and no cycle with both req_ready high.
- Backpressure: req1 XOR a=11 b=11, rsp_ready low for 5 cycles. Required: rsp_valid=1, rsp_data=00, rsp_zero=1, all outputs stable; req0 pending with ready held 0; req0 is accepted only after the handshake plus one cycle.
- EXEC_CYCLES=4: req0 AND a=89 b=11. Required: alu inputs stable 4 cycles; rsp_data=01 at accept+5.
- Reset during EXEC: assert rst_n low mid-operation. Required: rsp_valid=0, busy=0 and alu outputs 0 immediately; the post-reset tie is granted to requester 0.

Source files
------------

// File: rtl/alu_share_ctrl_if.sv
// Signal bundle between the issue logic, the shared-ALU controller and the ALU.
// The controller uses the slave view; the environment side uses the master view.
interface alu_share_ctrl_if #(
   parameter int WIDTH = 8
);
   logic             req0_valid;
   logic             req0_ready;
   logic [2:0]       req0_op;
   logic [WIDTH-1:0] req0_a;
   logic [WIDTH-1:0] req0_b;

   logic             req1_valid;
   logic             req1_ready;
   logic [2:0]       req1_op;
   logic [WIDTH-1:0] req1_a;
   logic [WIDTH-1:0] req1_b;

   logic [WIDTH-1:0] alu_a0;
   logic [WIDTH-1:0] alu_a1;
   logic             alu_a_sel;
   logic [WIDTH-1:0] alu_b;
   logic [2:0]       alu_ctrl;
   logic [WIDTH-1:0] alu_out;

   logic             rsp_valid;
   logic             rsp_ready;
   logic             rsp_id;
   logic [WIDTH-1:0] rsp_data;
   logic             rsp_zero;
   logic             busy;

   modport slave (
      input  req0_valid, req0_op, req0_a, req0_b,
             req1_valid, req1_op, req1_a, req1_b,
             alu_out, rsp_ready,
      output req0_ready, req1_ready,
             alu_a0, alu_a1, alu_a_sel, alu_b, alu_ctrl,
             rsp_valid, rsp_id, rsp_data, rsp_zero, busy
   );

   modport master (
      output req0_valid, req0_op, req0_a, req0_b,
             req1_valid, req1_op, req1_a, req1_b,
             alu_out, rsp_ready,
      input  req0_ready, req1_ready,
             alu_a0, alu_a1, alu_a_sel, alu_b, alu_ctrl,
             rsp_valid, rsp_id, rsp_data, rsp_zero, busy
   );
endinterface

// File: rtl/alu_share_ctrl.sv
// Round-robin sequencer sharing one combinational ALU between two requesters:
// accept, hold the ALU inputs for EXEC_CYCLES, capture, return a tagged response.
module alu_share_ctrl #(
   parameter int WIDTH       = 8,
   parameter int EXEC_CYCLES = 1
) (
   input logic             clk,
   input logic             rst_n,
   alu_share_ctrl_if.slave bus
);
   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_EXEC = 2'd1,
      S_RESP = 2'd2
   } state_e;

   localparam logic [3:0] CNT_LAST = 4'(EXEC_CYCLES - 1);

   state_e           state_q;
   logic [3:0]       cnt_q;
   logic             last_grant_q;
   logic [WIDTH-1:0] alu_a0_q;
   logic [WIDTH-1:0] alu_a1_q;
   logic             alu_a_sel_q;
   logic [WIDTH-1:0] alu_b_q;
   logic [2:0]       alu_ctrl_q;
   logic             rsp_valid_q;
   logic             rsp_id_q;
   logic [WIDTH-1:0] rsp_data_q;
   logic             rsp_zero_q;

   logic             accept_d;
   logic             grant_d;
   logic [2:0]       op_d;
   logic [WIDTH-1:0] a_d;
   logic [WIDTH-1:0] b_d;

   // A tie goes to the requester that was not served last.
   always_comb begin
      // NOTE: every always_comb output gets a default first, so no path can infer a latch.
      accept_d = 1'b0;
      grant_d  = 1'b0;
      if (state_q == S_IDLE) begin
         accept_d = bus.req0_valid | bus.req1_valid;
         if (bus.req0_valid && bus.req1_valid) begin
            grant_d = ~last_grant_q;
         end else begin
            grant_d = bus.req1_valid;
         end
      end
   end

   assign op_d = grant_d ? bus.req1_op : bus.req0_op;
   assign a_d  = grant_d ? bus.req1_a  : bus.req0_a;
   assign b_d  = grant_d ? bus.req1_b  : bus.req0_b;

   assign bus.req0_ready = accept_d & ~grant_d;
   assign bus.req1_ready = accept_d &  grant_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         // NOTE: datapath registers are reset too, so the ALU sees zeros and an in-flight op is discarded.
         state_q      <= S_IDLE;
         cnt_q        <= '0;
         last_grant_q <= 1'b1;
         alu_a0_q     <= '0;
         alu_a1_q     <= '0;
         alu_a_sel_q  <= 1'b0;
         alu_b_q      <= '0;
         alu_ctrl_q   <= '0;
         rsp_valid_q  <= 1'b0;
         rsp_id_q     <= 1'b0;
         rsp_data_q   <= '0;
         rsp_zero_q   <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments keep every register update based on pre-edge values.
         unique case (state_q)
            S_IDLE: begin
               if (accept_d) begin
                  // Only the granted requester's A lane is refreshed; the other lane persists.
                  if (grant_d) begin
                     alu_a1_q <= a_d;
                  end else begin
                     alu_a0_q <= a_d;
                  end
                  alu_b_q      <= b_d;
                  alu_ctrl_q   <= op_d;
                  alu_a_sel_q  <= grant_d;
                  last_grant_q <= grant_d;
                  cnt_q        <= '0;
                  state_q      <= S_EXEC;
               end
            end
            S_EXEC: begin
               cnt_q <= cnt_q + 4'd1;
               if (cnt_q == CNT_LAST) begin
                  rsp_data_q  <= bus.alu_out;
                  rsp_zero_q  <= (bus.alu_out == '0);
                  rsp_id_q    <= alu_a_sel_q;
                  rsp_valid_q <= 1'b1;
                  state_q     <= S_RESP;
               end
            end
            S_RESP: begin
               if (bus.rsp_ready) begin
                  rsp_valid_q <= 1'b0;
                  state_q     <= S_IDLE;
               end
            end
            default: begin
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   assign bus.alu_a0    = alu_a0_q;
   assign bus.alu_a1    = alu_a1_q;
   assign bus.alu_a_sel = alu_a_sel_q;
   assign bus.alu_b     = alu_b_q;
   assign bus.alu_ctrl  = alu_ctrl_q;
   assign bus.rsp_valid = rsp_valid_q;
   assign bus.rsp_id    = rsp_id_q;
   assign bus.rsp_data  = rsp_data_q;
   assign bus.rsp_zero  = rsp_zero_q;
   assign bus.busy      = (state_q != S_IDLE);
endmodule
